seg_scan_controller: RTL and testbench

- Parametrised time-multiplexing controller for multi-digit 7-segment displays; the next generation of the 2-bit free-running digit refresh counter.
- Adds an on-chip prescaler, arbitrary digit count (non-power-of-two wrap), per-digit enable mask, anti-ghosting blank window, an enable/freeze input, selectable anode polarity, and frame/tick strobes.
- Sits between the system clock and the segment decoder/anode pins: `sel` drives the digit-data mux and `anode` drives the pins directly.

---
 rtl/seg_scan_controller_pkg.sv | 23 ++
 rtl/seg_scan_controller_prescaler.sv | 35 +++
 rtl/seg_scan_controller.sv | 89 ++++++++
 tb/tb_seg_scan_controller.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg_scan_controller_pkg.sv
// Shared display helpers: constant clog2, anode polarity levels and the
// board-clock prescale default.
package seg_scan_controller_pkg;

  // Digit slot length for the board clock (100 MHz / 100000 = 1 kHz per digit).
  localparam int BOARD_CLK_DIV = 100000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic logic anode_on(input bit active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

  function automatic logic anode_off(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/seg_scan_controller_prescaler.sv
// Mod-CLK_DIV slot counter. Exposes its next-state value so the top can
// decode anodes aligned with the registered count.
module scan_prescaler #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  always_comb begin
    cnt_next = cnt;
    wrap     = 1'b0;
    if (en) begin
      if (cnt == CNT_LAST) begin
        cnt_next = '0;
        wrap     = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_next;
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 7-segment digit scanner with prescaler, digit mask,
// anti-ghosting blank window at the start of each slot, and freeze input.
module seg_scan_controller
  import seg_scan_controller_pkg::*;
#(
  parameter int  NUM_DIGITS       = 4,
  parameter int  CLK_DIV          = BOARD_CLK_DIV,
  parameter int  BLANK_CYCLES     = 16,
  parameter bit  ANODE_ACTIVE_LOW = 1'b1,
  localparam int SEL_W            = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic [SEL_W-1:0]      sel,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  scan_tick,
  output logic                  frame_start
);

  localparam int CNT_W = clog2(CLK_DIV);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
  localparam logic A_ON  = anode_on(ANODE_ACTIVE_LOW);
  localparam logic A_OFF = anode_off(ANODE_ACTIVE_LOW);

  generate
    if (NUM_DIGITS < 1 || CLK_DIV < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_params
      $error("seg_scan_controller: illegal NUM_DIGITS/CLK_DIV/BLANK_CYCLES combination");
    end
  endgenerate

  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  wrap;
  logic [SEL_W-1:0]      sel_next;
  logic                  past_blank;
  logic [NUM_DIGITS-1:0] anode_next;

  scan_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cnt      (cnt),
    .cnt_next (cnt_next),
    .wrap     (wrap)
  );

  // With no blank window the comparison is trivially true, so skip it.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign past_blank = 1'b1;
    end else begin : g_blank
      assign past_blank = (cnt_next >= CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  always_comb begin
    sel_next = sel;
    if (wrap) sel_next = (sel == SEL_LAST) ? '0 : sel + 1'b1;
  end

  // Decode from next-state values so anode lines up with the registered sel.
  always_comb begin
    anode_next = {NUM_DIGITS{A_OFF}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en && past_blank && digit_en[sel_next] && (sel_next == SEL_W'(i)))
        anode_next[i] = A_ON;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel         <= '0;
      anode       <= {NUM_DIGITS{A_OFF}};
      scan_tick   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sel         <= sel_next;
      anode       <= anode_next;
      scan_tick   <= wrap;
      frame_start <= wrap && (sel == SEL_LAST);
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: a 3-digit active-low instance and a
// 1-digit active-high instance, each with its own expected queue and monitor.
module tb_seg_scan_controller;

  localparam int W  = 9;
  localparam int W1 = 4;
  localparam logic [2:0] OFF = 3'b111;
  localparam logic [2:0] D0  = 3'b110;
  localparam logic [2:0] D1  = 3'b101;
  localparam logic [2:0] D2  = 3'b011;

  logic       clk = 1'b0;
  logic       rst_n, en;
  logic [2:0] digit_en;
  logic [1:0] sel;
  logic [2:0] anode;
  logic       scan_tick, frame_start;

  logic       rst1_n, en1;
  logic [0:0] digit_en1;
  logic [0:0] sel1;
  logic [0:0] anode1;
  logic       tick1, frame1;

  logic [W-1:0]  exp_q[$];
  logic [W1-1:0] exp1_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_idx = 0;
  int cyc1_idx = 0;

  always #5 clk = ~clk;

  seg_scan_controller #(
    .NUM_DIGITS(3), .CLK_DIV(4), .BLANK_CYCLES(1), .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digit_en(digit_en),
    .sel(sel), .anode(anode), .scan_tick(scan_tick), .frame_start(frame_start)
  );

  seg_scan_controller #(
    .NUM_DIGITS(1), .CLK_DIV(2), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .digit_en(digit_en1),
    .sel(sel1), .anode(anode1), .scan_tick(tick1), .frame_start(frame1)
  );

  // Expected word: {cnt, sel, anode, scan_tick, frame_start} after the edge.
  task automatic cyc(input logic r, input logic e, input logic [2:0] de,
                     input logic [1:0] c, input logic [1:0] s,
                     input logic [2:0] a, input logic t, input logic f);
    rst_n    = r;
    en       = e;
    digit_en = de;
    @(posedge clk);
    #1;
    exp_q.push_back({c, s, a, t, f});
  endtask

  task automatic cyc1(input logic r, input logic [W1-1:0] expv);
    rst1_n    = r;
    en1       = 1'b1;
    digit_en1 = 1'b1;
    @(posedge clk);
    #1;
    exp1_q.push_back(expv);
  endtask

  always @(negedge clk) begin
    logic [W-1:0] want, got;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {dut.cnt, sel, anode, scan_tick, frame_start};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL main_edge%0d got cnt/sel/anode/tick/frame=%b want %b", cyc_idx, got, want);
      end
      cyc_idx++;
    end
  end

  always @(negedge clk) begin
    logic [W1-1:0] want, got;
    if (exp1_q.size() > 0) begin
      want = exp1_q.pop_front();
      got  = {sel1, anode1, tick1, frame1};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single_edge%0d got sel/anode/tick/frame=%b want %b", cyc1_idx, got, want);
      end
      cyc1_idx++;
    end
  end

  // Single-digit, active-high, no blanking: anode stays lit, ticks every 2 cycles.
  initial begin
    cyc1(1'b0, 4'b0000);
    cyc1(1'b0, 4'b0000);
    cyc1(1'b1, 4'b0100);
    cyc1(1'b1, 4'b0111);
    cyc1(1'b1, 4'b0100);
    cyc1(1'b1, 4'b0111);
    cyc1(1'b1, 4'b0100);
    cyc1(1'b1, 4'b0111);
    cyc1(1'b1, 4'b0100);
    cyc1(1'b1, 4'b0111);
  end

  initial begin
    // Reset held for two edges.
    cyc(0, 0, 3'b111, 0, 0, OFF, 0, 0);
    cyc(0, 0, 3'b111, 0, 0, OFF, 0, 0);
    // Full frame, all digits enabled; one blank cycle at each slot start.
    cyc(1, 1, 3'b111, 1, 0, D0,  0, 0);
    cyc(1, 1, 3'b111, 2, 0, D0,  0, 0);
    cyc(1, 1, 3'b111, 3, 0, D0,  0, 0);
    cyc(1, 1, 3'b111, 0, 1, OFF, 1, 0);
    cyc(1, 1, 3'b111, 1, 1, D1,  0, 0);
    cyc(1, 1, 3'b111, 2, 1, D1,  0, 0);
    cyc(1, 1, 3'b111, 3, 1, D1,  0, 0);
    cyc(1, 1, 3'b111, 0, 2, OFF, 1, 0);
    cyc(1, 1, 3'b111, 1, 2, D2,  0, 0);
    cyc(1, 1, 3'b111, 2, 2, D2,  0, 0);
    cyc(1, 1, 3'b111, 3, 2, D2,  0, 0);
    cyc(1, 1, 3'b111, 0, 0, OFF, 1, 1);
    cyc(1, 1, 3'b111, 1, 0, D0,  0, 0);
    cyc(1, 1, 3'b111, 2, 0, D0,  0, 0);
    cyc(1, 1, 3'b111, 3, 0, D0,  0, 0);
    // Digit 1 masked for a full frame.
    cyc(1, 1, 3'b101, 0, 1, OFF, 1, 0);
    cyc(1, 1, 3'b101, 1, 1, OFF, 0, 0);
    cyc(1, 1, 3'b101, 2, 1, OFF, 0, 0);
    cyc(1, 1, 3'b101, 3, 1, OFF, 0, 0);
    cyc(1, 1, 3'b101, 0, 2, OFF, 1, 0);
    cyc(1, 1, 3'b101, 1, 2, D2,  0, 0);
    cyc(1, 1, 3'b101, 2, 2, D2,  0, 0);
    cyc(1, 1, 3'b101, 3, 2, D2,  0, 0);
    cyc(1, 1, 3'b101, 0, 0, OFF, 1, 1);
    cyc(1, 1, 3'b101, 1, 0, D0,  0, 0);
    cyc(1, 1, 3'b101, 2, 0, D0,  0, 0);
    cyc(1, 1, 3'b101, 3, 0, D0,  0, 0);
    // Freeze at sel=1, cnt=2 for five edges, then resume without restarting the slot.
    cyc(1, 1, 3'b111, 0, 1, OFF, 1, 0);
    cyc(1, 1, 3'b111, 1, 1, D1,  0, 0);
    cyc(1, 1, 3'b111, 2, 1, D1,  0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 3'b111, 2, 1, OFF, 0, 0);
    cyc(1, 1, 3'b111, 3, 1, D1,  0, 0);
    cyc(1, 1, 3'b111, 0, 2, OFF, 1, 0);
    cyc(1, 1, 3'b111, 1, 2, D2,  0, 0);
    cyc(1, 1, 3'b111, 2, 2, D2,  0, 0);
    cyc(1, 1, 3'b111, 3, 2, D2,  0, 0);
    // Reset at sel=2, cnt=3: would have been a wrap edge, must produce no pulses.
    cyc(0, 1, 3'b111, 0, 0, OFF, 0, 0);
    cyc(1, 1, 3'b111, 1, 0, D0,  0, 0);
    cyc(1, 1, 3'b111, 2, 0, D0,  0, 0);
    // Mask digit 0 mid-slot: anode drops at the very next edge.
    cyc(1, 1, 3'b110, 3, 0, OFF, 0, 0);
    cyc(1, 1, 3'b111, 0, 1, OFF, 1, 0);
    cyc(1, 1, 3'b111, 1, 1, D1,  0, 0);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0/0", exp_q.size(), exp1_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
